// File: rtl/bluemax_timer_pkg.sv
// Shared constants for the bluemax timer master: op-codes, register map,
// control bit positions and FSM state encoding.
package bluemax_timer_pkg;

    localparam logic [1:0] OpStart    = 2'b00;
    localparam logic [1:0] OpStop     = 2'b01;
    localparam logic [1:0] OpSnapshot = 2'b10;
    localparam logic [1:0] OpReserved = 2'b11;

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrPeriodL = 3'd2;
    localparam logic [2:0] AddrPeriodH = 3'd3;
    localparam logic [2:0] AddrSnapL   = 3'd4;
    localparam logic [2:0] AddrSnapH   = 3'd5;

    localparam int unsigned CtrlIto   = 0;
    localparam int unsigned CtrlCont  = 1;
    localparam int unsigned CtrlStart = 2;
    localparam int unsigned CtrlStop  = 3;

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StWrPerl    = 4'd1;
    localparam logic [3:0] StWrPerh    = 4'd2;
    localparam logic [3:0] StWrCtrl    = 4'd3;
    localparam logic [3:0] StWrStop    = 4'd4;
    localparam logic [3:0] StWrSnap    = 4'd5;
    localparam logic [3:0] StRdL       = 4'd6;
    localparam logic [3:0] StWaitL     = 4'd7;
    localparam logic [3:0] StRdH       = 4'd8;
    localparam logic [3:0] StWaitH     = 4'd9;
    localparam logic [3:0] StSnapOut   = 4'd10;
    localparam logic [3:0] StClrStatus = 4'd11;
    localparam logic [3:0] StGuard     = 4'd12;

endpackage

// File: rtl/bluemax_timer_master.sv
// Command-driven bus master for an interval timer: programs period/control,
// takes counter snapshots and services the timeout interrupt.
module bluemax_timer_master
    import bluemax_timer_pkg::*;
#(
    parameter int unsigned READ_LATENCY     = 1,
    parameter bit          CONTINUOUS       = 1'b1,
    parameter logic [15:0] TICK_COUNT_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        busy
);

    localparam logic [15:0] CtrlStartWord = (16'(1) << CtrlIto) | (16'(CONTINUOUS) << CtrlCont) |
                                            (16'(1) << CtrlStart);
    localparam logic [15:0] CtrlStopWord  = 16'(1) << CtrlStop;

    logic [3:0]  state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] tick_count_q, tick_count_d;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        wait_d       = wait_q;
        tick_count_d = tick_count_q;
        unique case (state_q)
            StIdle: begin
                // irq wins over a command offered in the same cycle
                if (irq) begin
                    state_d      = StClrStatus;
                    tick_count_d = tick_count_q + 16'd1;
                end else if (cmd_valid) begin
                    unique case (cmd_op)
                        OpStart: begin
                            period_d = cmd_period;
                            state_d  = StWrPerl;
                        end
                        OpStop:     state_d = StWrStop;
                        OpSnapshot: state_d = StWrSnap;
                        OpReserved: state_d = StIdle;
                    endcase
                end
            end
            StWrPerl: state_d = StWrPerh;
            StWrPerh: state_d = StWrCtrl;
            StWrCtrl: state_d = StIdle;
            StWrStop: state_d = StIdle;
            StWrSnap: state_d = StRdL;
            StRdL: begin
                wait_d  = 2'(READ_LATENCY - 1);
                state_d = StWaitL;
            end
            StWaitL: begin
                if (wait_q == 2'd0) begin
                    snap_lo_d = readdata;
                    state_d   = StRdH;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StRdH: begin
                wait_d  = 2'(READ_LATENCY - 1);
                state_d = StWaitH;
            end
            StWaitH: begin
                if (wait_q == 2'd0) begin
                    snap_value_d = {readdata, snap_lo_q};
                    state_d      = StSnapOut;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StSnapOut:   state_d = StIdle;
            StClrStatus: state_d = StGuard;
            // one dead cycle lets the timer drop irq before it is sampled again
            StGuard:     state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'h0000;
        unique case (state_q)
            StWrPerl: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrPeriodL;
                writedata  = period_q[15:0];
            end
            StWrPerh: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrPeriodH;
                writedata  = period_q[31:16];
            end
            StWrCtrl: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrControl;
                writedata  = CtrlStartWord;
            end
            StWrStop: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrControl;
                writedata  = CtrlStopWord;
            end
            StWrSnap: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrSnapL;
            end
            StRdL: begin
                chipselect = 1'b1;
                address    = AddrSnapL;
            end
            StRdH: begin
                chipselect = 1'b1;
                address    = AddrSnapH;
            end
            StClrStatus: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = AddrStatus;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            period_q     <= '0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            wait_q       <= '0;
            tick_count_q <= TICK_COUNT_RESET;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            wait_q       <= wait_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle) && !irq && !reset;
    assign busy       = (state_q != StIdle);
    assign tick       = (state_q == StClrStatus);
    assign snap_valid = (state_q == StSnapOut);
    assign tick_count = tick_count_q;
    assign snap_value = snap_value_q;

endmodule

// File: tb/tb_bluemax_timer_master.sv
// Scoreboard bench: instance a uses READ_LATENCY=1, instance b uses READ_LATENCY=3
// with tick_count preloaded to 0xFFFF to exercise the wrap.
module tb_bluemax_timer_master;
    import bluemax_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, irq;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;

    logic        a_cmd_ready, a_chipselect, a_write_n, a_tick, a_snap_valid, a_busy;
    logic [2:0]  a_address;
    logic [15:0] a_writedata, a_readdata, a_tick_count;
    logic [31:0] a_snap_value;
    logic        b_cmd_ready, b_chipselect, b_write_n, b_tick, b_snap_valid, b_busy;
    logic [2:0]  b_address;
    logic [15:0] b_writedata, b_readdata, b_tick_count;
    logic [31:0] b_snap_value;

    logic [15:0] slv_lo, slv_hi;
    logic [15:0] pipe_a [4];
    logic [15:0] pipe_b [4];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] exp_bus_a [$];
    logic [19:0] exp_bus_b [$];
    logic [31:0] exp_snap_a [$];
    logic [31:0] exp_snap_b [$];
    logic [15:0] exp_ticks_a, exp_ticks_b;

    always #5 clk = ~clk;

    bluemax_timer_master #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .address(a_address),
        .chipselect(a_chipselect), .write_n(a_write_n), .writedata(a_writedata),
        .readdata(a_readdata), .irq(irq), .tick(a_tick), .tick_count(a_tick_count),
        .snap_valid(a_snap_valid), .snap_value(a_snap_value), .busy(a_busy)
    );

    bluemax_timer_master #(.READ_LATENCY(3), .TICK_COUNT_RESET(16'hFFFF)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .address(b_address),
        .chipselect(b_chipselect), .write_n(b_write_n), .writedata(b_writedata),
        .readdata(b_readdata), .irq(irq), .tick(b_tick), .tick_count(b_tick_count),
        .snap_valid(b_snap_valid), .snap_value(b_snap_value), .busy(b_busy)
    );

    // Slave model: snapshot data appears only in the cycle READ_LATENCY after the read
    function automatic logic [15:0] slave_data(input logic cs, input logic wn,
                                               input logic [2:0] addr);
        if (cs && wn && addr == 3'd4) return slv_lo;
        if (cs && wn && addr == 3'd5) return slv_hi;
        return 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pipe_a[i] <= 16'h0000;
                pipe_b[i] <= 16'h0000;
            end
        end else begin
            pipe_a[0] <= slave_data(a_chipselect, a_write_n, a_address);
            pipe_b[0] <= slave_data(b_chipselect, b_write_n, b_address);
            for (int i = 1; i < 4; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end
    assign a_readdata = pipe_a[0];
    assign b_readdata = pipe_b[2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic push_bus(input logic [2:0] addr, input logic wn, input logic [15:0] data);
        exp_bus_a.push_back({addr, wn, data});
        exp_bus_b.push_back({addr, wn, data});
    endtask

    task automatic monitor();
        logic [19:0] e;
        logic [31:0] s;
        forever begin
            @(negedge clk);
            n_checks++;
            if (a_chipselect) begin
                if (exp_bus_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_a_unexpected: got %h, required no bus cycle",
                             {a_address, a_write_n, a_writedata});
                end else begin
                    e = exp_bus_a.pop_front();
                    if ({a_address, a_write_n, a_writedata} !== e) begin
                        n_fail++;
                        $display("FAIL bus_a: got %h, required %h",
                                 {a_address, a_write_n, a_writedata}, e);
                    end
                end
            end else if ({a_address, a_write_n, a_writedata} !== {3'd0, 1'b1, 16'h0}) begin
                n_fail++;
                $display("FAIL bus_a_idle: got %h, required %h",
                         {a_address, a_write_n, a_writedata}, {3'd0, 1'b1, 16'h0});
            end
            n_checks++;
            if (b_chipselect) begin
                if (exp_bus_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_b_unexpected: got %h, required no bus cycle",
                             {b_address, b_write_n, b_writedata});
                end else begin
                    e = exp_bus_b.pop_front();
                    if ({b_address, b_write_n, b_writedata} !== e) begin
                        n_fail++;
                        $display("FAIL bus_b: got %h, required %h",
                                 {b_address, b_write_n, b_writedata}, e);
                    end
                end
            end else if ({b_address, b_write_n, b_writedata} !== {3'd0, 1'b1, 16'h0}) begin
                n_fail++;
                $display("FAIL bus_b_idle: got %h, required %h",
                         {b_address, b_write_n, b_writedata}, {3'd0, 1'b1, 16'h0});
            end
            if (a_snap_valid) begin
                n_checks++;
                s = (exp_snap_a.size() != 0) ? exp_snap_a.pop_front() : 32'hxxxx_xxxx;
                if (a_snap_value !== s) begin
                    n_fail++;
                    $display("FAIL snap_a: got %h, required %h", a_snap_value, s);
                end
            end
            if (b_snap_valid) begin
                n_checks++;
                s = (exp_snap_b.size() != 0) ? exp_snap_b.pop_front() : 32'hxxxx_xxxx;
                if (b_snap_value !== s) begin
                    n_fail++;
                    $display("FAIL snap_b: got %h, required %h", b_snap_value, s);
                end
            end
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = !a_busy && !b_busy;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: busy a=%0b b=%0b, required 0", a_busy, b_busy);
        end
    endtask

    // Returns at the negedge of the acceptance cycle N
    task automatic issue(input logic [1:0] op, input logic [31:0] period);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_period = period;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = a_cmd_ready;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%0b, required 1", a_cmd_ready);
        end
    endtask

    task automatic release_cmd();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; irq = 1'b0; cmd_op = 2'b00; cmd_period = '0;
        slv_lo = 16'h0; slv_hi = 16'h0;
        exp_ticks_a = 16'h0000; exp_ticks_b = 16'hFFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_cmd_ready, a_busy, a_tick, a_snap_valid, a_chipselect} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {a_cmd_ready, a_busy, a_tick, a_snap_valid, a_chipselect});
        end
        n_checks++;
        if ({a_tick_count, a_snap_value} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h, required 0", {a_tick_count, a_snap_value});
        end
        n_checks++;
        if (b_tick_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_preload_b: got %h, required ffff", b_tick_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cmd_ready, b_cmd_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 11", {a_cmd_ready, b_cmd_ready});
        end
    endtask

    task automatic test_irq_priority();
        wait_idle();
        push_bus(AddrStatus, 1'b0, 16'h0000);
        push_bus(AddrControl, 1'b0, 16'h0008);
        @(posedge clk);
        #1;
        irq = 1'b1; cmd_valid = 1'b1; cmd_op = OpStop;
        @(negedge clk);
        n_checks++;
        if (a_cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_blocks_ready: got %0b, required 0", a_cmd_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({a_tick, b_tick} !== 2'b11) begin
            n_fail++;
            $display("FAIL irq_tick: got %b, required 11", {a_tick, b_tick});
        end
        @(posedge clk);
        #1;
        irq = 1'b0;
        exp_ticks_a = exp_ticks_a + 16'd1;
        exp_ticks_b = exp_ticks_b + 16'd1;
        @(negedge clk);
        n_checks++;
        if ({a_tick_count, b_tick_count} !== {exp_ticks_a, exp_ticks_b}) begin
            n_fail++;
            $display("FAIL tick_count_wrap: got %h %h, required %h %h",
                     a_tick_count, b_tick_count, exp_ticks_a, exp_ticks_b);
        end
        @(negedge clk);
        n_checks++;
        if (a_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_after_irq: cmd_ready got %0b, required 1", a_cmd_ready);
        end
        release_cmd();
    endtask

    task automatic test_start(input logic [31:0] period);
        wait_idle();
        push_bus(AddrPeriodL, 1'b0, period[15:0]);
        push_bus(AddrPeriodH, 1'b0, period[31:16]);
        push_bus(AddrControl, 1'b0, 16'h0007);
        issue(OpStart, period);
        release_cmd();
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if ({a_chipselect, a_busy} !== ((k < 4) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL start_timing N+%0d: cs/busy got %b, required %b", k,
                         {a_chipselect, a_busy}, (k < 4) ? 2'b11 : 2'b00);
            end
            if (k < 4) @(negedge clk);
        end
    endtask

    task automatic test_stop();
        wait_idle();
        push_bus(AddrControl, 1'b0, 16'h0008);
        issue(OpStop, 32'h0);
        release_cmd();
        n_checks++;
        if ({a_chipselect, a_cmd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL stop_n1: cs/ready got %b, required 10", {a_chipselect, a_cmd_ready});
        end
        @(negedge clk);
        n_checks++;
        if (a_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_ready_n2: got %0b, required 1", a_cmd_ready);
        end
    endtask

    task automatic test_snapshot(input logic [15:0] lo, input logic [15:0] hi);
        int ka = -1, kb = -1, na = 0, nb = 0;
        wait_idle();
        slv_lo = lo;
        slv_hi = hi;
        push_bus(AddrSnapL, 1'b0, 16'h0000);
        push_bus(AddrSnapL, 1'b1, 16'h0000);
        push_bus(AddrSnapH, 1'b1, 16'h0000);
        exp_snap_a.push_back({hi, lo});
        exp_snap_b.push_back({hi, lo});
        issue(OpSnapshot, 32'h0);
        release_cmd();
        for (int k = 1; k <= 14; k++) begin
            if (a_snap_valid) begin na++; ka = k; end
            if (b_snap_valid) begin nb++; kb = k; end
            if (k < 14) @(negedge clk);
        end
        n_checks++;
        if (na != 1 || ka != 6) begin
            n_fail++;
            $display("FAIL snap_timing_a: %0d pulses at N+%0d, required 1 at N+6", na, ka);
        end
        n_checks++;
        if (nb != 1 || kb != 10) begin
            n_fail++;
            $display("FAIL snap_timing_b: %0d pulses at N+%0d, required 1 at N+10", nb, kb);
        end
        n_checks++;
        if (a_snap_value !== {hi, lo}) begin
            n_fail++;
            $display("FAIL snap_hold: got %h, required %h", a_snap_value, {hi, lo});
        end
    endtask

    task automatic test_reserved();
        wait_idle();
        issue(OpReserved, 32'h0);
        release_cmd();
        n_checks++;
        if ({a_chipselect, a_busy, a_cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reserved_op: cs/busy/ready got %b, required 001",
                     {a_chipselect, a_busy, a_cmd_ready});
        end
    endtask

    task automatic test_irq_held();
        int ticks = 0;
        logic exp_tick;
        wait_idle();
        repeat (4) push_bus(AddrStatus, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        irq = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            exp_tick = (k % 3 == 1) && (k <= 10);
            if (a_tick) ticks++;
            n_checks++;
            if (a_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL irq_held_tick S+%0d: got %0b, required %0b", k, a_tick, exp_tick);
            end
            if (k == 11) begin
                @(posedge clk);
                #1;
                irq = 1'b0;
            end
        end
        exp_ticks_a = exp_ticks_a + 16'd4;
        exp_ticks_b = exp_ticks_b + 16'd4;
        n_checks++;
        if (ticks != 4 || a_tick_count !== exp_ticks_a || b_tick_count !== exp_ticks_b) begin
            n_fail++;
            $display("FAIL irq_held_count: %0d ticks, counts %h %h, required 4, %h %h",
                     ticks, a_tick_count, b_tick_count, exp_ticks_a, exp_ticks_b);
        end
    endtask

    task automatic test_irq_busy();
        wait_idle();
        push_bus(AddrControl, 1'b0, 16'h0008);
        push_bus(AddrStatus, 1'b0, 16'h0000);
        issue(OpStop, 32'h0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        irq = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ignored_busy: tick got %0b, required 0", a_tick);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_after_busy: tick at N+3 got %0b, required 1", a_tick);
        end
        @(posedge clk);
        #1;
        irq = 1'b0;
        exp_ticks_a = exp_ticks_a + 16'd1;
        exp_ticks_b = exp_ticks_b + 16'd1;
    endtask

    task automatic test_reset_mid();
        wait_idle();
        push_bus(AddrPeriodL, 1'b0, 16'h0003);
        push_bus(AddrPeriodH, 1'b0, 16'h0002);
        issue(OpStart, 32'h0002_0003);
        release_cmd();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_chipselect, a_cmd_ready, a_tick, a_snap_valid, a_busy} !== 5'b0 ||
            {a_address, a_write_n, a_writedata} !== {3'd0, 1'b1, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_bus: flags %b bus %h, required 00000 and %h",
                     {a_chipselect, a_cmd_ready, a_tick, a_snap_valid, a_busy},
                     {a_address, a_write_n, a_writedata}, {3'd0, 1'b1, 16'h0});
        end
        n_checks++;
        if ({a_tick_count, a_snap_value, b_snap_value} !== 80'h0 || b_tick_count !== 16'hFFFF ||
            b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_values: got %h %h %h %h %0b, required 0 0 0 ffff 0",
                     a_tick_count, a_snap_value, b_snap_value, b_tick_count, b_busy);
        end
        exp_ticks_a = 16'h0000;
        exp_ticks_b = 16'hFFFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %0b, required 1", a_cmd_ready);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_irq_priority();
        test_start(32'h0001_86A0);
        test_start(32'h0000_0000);
        test_stop();
        test_snapshot(16'h1234, 16'hABCD);
        test_snapshot(16'h00C3, 16'h5A5A);
        test_reserved();
        test_irq_held();
        test_irq_busy();
        test_reset_mid();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_bus_a.size() != 0 || exp_bus_b.size() != 0 || exp_snap_a.size() != 0 ||
            exp_snap_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left %0d %0d %0d %0d, required 0 0 0 0",
                     exp_bus_a.size(), exp_bus_b.size(), exp_snap_a.size(), exp_snap_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
